// File: rtl/imm_pkg.sv
// Shared decode-stage types: immediate format encodings and skid-buffer occupancy.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_NONE  = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } occ_state_e;

    localparam int INSTR_W = 32;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle for the pipelined immediate generator.
import imm_pkg::*;

interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    imm_src_e            in_imm_src;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_imm;
    logic [TAG_W-1:0]    out_tag;
    logic                out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Pure combinational RISC-V immediate extractor, sign/zero-extended to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    output logic [XLEN-1:0]    imm,
    output logic               illegal
);

    // Opcode bits never feed an immediate field.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:    imm = XLEN'($signed(instr[31:20]));
            IMM_S:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:    imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_SHAMT: begin
                // A 6-bit shift amount only exists on RV64; on RV32 bit 25 flags the result.
                if (XLEN == 64) begin
                    imm = XLEN'(instr[25:20]);
                end else begin
                    imm     = XLEN'(instr[24:20]);
                    illegal = instr[25];
                end
            end
            IMM_ZIMM: imm = XLEN'(instr[19:15]);
            IMM_NONE: imm = '0;
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer (output reg + skid reg).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    occ_state_e       state_q;
    occ_state_e       state_d;

    logic [XLEN-1:0]  or_imm;
    logic [TAG_W-1:0] or_tag;
    logic             or_illegal;
    logic [XLEN-1:0]  sk_imm;
    logic [TAG_W-1:0] sk_tag;
    logic             sk_illegal;

    logic accept;
    logic drain;
    logic load_or_in;
    logic load_or_sk;
    logic load_sk;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .imm_src (bus.in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Ready/valid are decodes of the state register only, so out_ready never reaches in_ready.
    assign bus.in_ready    = (state_q != FULL);
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_imm     = or_imm;
    assign bus.out_tag     = or_tag;
    assign bus.out_illegal = or_illegal;

    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign drain  = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        load_or_in = 1'b0;
        load_or_sk = 1'b0;
        load_sk    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    load_or_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_or_in = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    load_sk = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d    = ONE;
                    load_or_sk = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d    = EMPTY;
            load_or_in = 1'b0;
            load_or_sk = 1'b0;
            load_sk    = 1'b0;
        end
    end

    // The output register is cleared on reset so the visible result reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            or_imm     <= '0;
            or_tag     <= '0;
            or_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_or_in) begin
                or_imm     <= dec_imm;
                or_tag     <= bus.in_tag;
                or_illegal <= dec_illegal;
            end else if (load_or_sk) begin
                or_imm     <= sk_imm;
                or_tag     <= sk_tag;
                or_illegal <= sk_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_sk) begin
            sk_imm     <= dec_imm;
            sk_tag     <= bus.in_tag;
            sk_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench driving an XLEN=32 and an XLEN=64 instance in lockstep.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) if64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    task automatic applyStimulus(input logic valid, input imm_src_e src, input logic [31:0] instr,
                                 input logic [7:0] tag, input logic ready, input logic flush);
        if32.in_valid   = valid;
        if32.in_imm_src = src;
        if32.in_instr   = instr;
        if32.in_tag     = tag;
        if32.out_ready  = ready;
        if32.flush      = flush;
        if64.in_valid   = valid;
        if64.in_imm_src = src;
        if64.in_instr   = instr;
        if64.in_tag     = tag;
        if64.out_ready  = ready;
        if64.flush      = flush;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic checkStatus(input string name, input logic valid, input logic ready);
        checkOutput({name, "_valid32"}, 64'(if32.out_valid), 64'(valid));
        checkOutput({name, "_ready32"}, 64'(if32.in_ready),  64'(ready));
        checkOutput({name, "_valid64"}, 64'(if64.out_valid), 64'(valid));
        checkOutput({name, "_ready64"}, 64'(if64.in_ready),  64'(ready));
    endtask

    task automatic checkResult(input string name, input logic [7:0] tag,
                               input logic [31:0] exp32, input logic ill32,
                               input logic [63:0] exp64, input logic ill64);
        checkOutput({name, "_valid32"}, 64'(if32.out_valid),   64'd1);
        checkOutput({name, "_tag32"},   64'(if32.out_tag),     64'(tag));
        checkOutput({name, "_imm32"},   64'(if32.out_imm),     64'(exp32));
        checkOutput({name, "_ill32"},   64'(if32.out_illegal), 64'(ill32));
        checkOutput({name, "_tag64"},   64'(if64.out_tag),     64'(tag));
        checkOutput({name, "_imm64"},   if64.out_imm,          exp64);
        checkOutput({name, "_ill64"},   64'(if64.out_illegal), 64'(ill64));
    endtask

    task automatic runVector(input string name, input imm_src_e src, input logic [31:0] instr,
                             input logic [7:0] tag, input logic [31:0] exp32, input logic ill32,
                             input logic [63:0] exp64, input logic ill64);
        applyStimulus(1'b1, src, instr, tag, 1'b1, 1'b0);
        step();
        checkResult(name, tag, exp32, ill32, exp64, ill64);
    endtask

    // I-type word whose immediate equals the tag, so order is visible in both fields.
    function automatic logic [31:0] tagInstr(input logic [7:0] k);
        return {4'h0, k, 20'h00093};
    endfunction

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, IMM_I, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        checkStatus("reset", 1'b0, 1'b1);
        checkOutput("reset_imm32", 64'(if32.out_imm), 64'd0);
        checkOutput("reset_tag32", 64'(if32.out_tag), 64'd0);
        checkOutput("reset_ill32", 64'(if32.out_illegal), 64'd0);
        checkOutput("reset_imm64", if64.out_imm, 64'd0);
        rst_n = 1'b1;

        runVector("i_pos",  IMM_I,     32'h7FF00093, 8'd1,  32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0);
        runVector("i_neg",  IMM_I,     32'h80000093, 8'd2,  32'hFFFFF800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0);
        runVector("s_neg",  IMM_S,     32'hFE112E23, 8'd3,  32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        runVector("u_pos",  IMM_U,     32'h12345037, 8'd4,  32'h12345000, 1'b0, 64'h0000000012345000, 1'b0);
        runVector("u_neg",  IMM_U,     32'h80000037, 8'd5,  32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
        runVector("j_neg",  IMM_J,     32'hFFF0016F, 8'd6,  32'hFFF00FFE, 1'b0, 64'hFFFFFFFFFFF00FFE, 1'b0);
        runVector("b_neg",  IMM_B,     32'hFE512EE3, 8'd7,  32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        runVector("zimm",   IMM_ZIMM,  32'h000FD073, 8'd8,  32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
        runVector("shamt",  IMM_SHAMT, 32'h03F09093, 8'd9,  32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0);
        runVector("none",   IMM_NONE,  32'hFFFFFFFF, 8'd10, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0);
        applyStimulus(1'b0, IMM_I, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkStatus("drained", 1'b0, 1'b1);

        // Back-pressure: two entries fill the buffer, the third waits.
        applyStimulus(1'b1, IMM_I, tagInstr(8'd1), 8'd1, 1'b0, 1'b0);
        step();
        checkStatus("bp_first", 1'b1, 1'b1);
        checkOutput("bp_first_tag", 64'(if32.out_tag), 64'd1);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd2), 8'd2, 1'b0, 1'b0);
        step();
        checkStatus("bp_full", 1'b1, 1'b0);
        checkOutput("bp_full_tag", 64'(if32.out_tag), 64'd1);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd3), 8'd3, 1'b0, 1'b0);
        step();
        checkStatus("bp_stall", 1'b1, 1'b0);
        checkOutput("bp_stall_tag", 64'(if32.out_tag), 64'd1);
        checkOutput("bp_stall_imm", 64'(if32.out_imm), 64'd1);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd3), 8'd3, 1'b1, 1'b0);
        step();
        checkStatus("bp_rel2", 1'b1, 1'b1);
        checkResult("bp_out2", 8'd2, 32'd2, 1'b0, 64'd2, 1'b0);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd3), 8'd3, 1'b1, 1'b0);
        step();
        checkResult("bp_out3", 8'd3, 32'd3, 1'b0, 64'd3, 1'b0);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd4), 8'd4, 1'b1, 1'b0);
        step();
        checkResult("bp_out4", 8'd4, 32'd4, 1'b0, 64'd4, 1'b0);
        applyStimulus(1'b0, IMM_I, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkStatus("bp_empty", 1'b0, 1'b1);

        // Flush from FULL, then flush while ready to show the request is dropped.
        applyStimulus(1'b1, IMM_I, tagInstr(8'd5), 8'd5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, IMM_I, tagInstr(8'd6), 8'd6, 1'b0, 1'b0);
        step();
        checkStatus("fl_full", 1'b1, 1'b0);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd7), 8'd7, 1'b0, 1'b1);
        step();
        checkStatus("fl_after", 1'b0, 1'b1);
        applyStimulus(1'b1, IMM_I, tagInstr(8'd8), 8'd8, 1'b1, 1'b1);
        step();
        checkStatus("fl_drop", 1'b0, 1'b1);
        applyStimulus(1'b0, IMM_I, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkStatus("fl_quiet", 1'b0, 1'b1);

        // Mid-stream reset with a full buffer and a pending request.
        applyStimulus(1'b1, IMM_I, tagInstr(8'd9), 8'd9, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, IMM_I, tagInstr(8'd10), 8'd10, 1'b0, 1'b0);
        step();
        checkStatus("rs_full", 1'b1, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, IMM_I, tagInstr(8'd11), 8'd11, 1'b1, 1'b0);
        step();
        checkStatus("rs_after", 1'b0, 1'b1);
        checkOutput("rs_imm", 64'(if32.out_imm), 64'd0);
        checkOutput("rs_tag", 64'(if32.out_tag), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, IMM_I, tagInstr(8'd12), 8'd12, 1'b1, 1'b0);
        step();
        checkStatus("rs_first", 1'b1, 1'b1);
        checkResult("rs_first", 8'd12, 32'd12, 1'b0, 64'd12, 1'b0);
        applyStimulus(1'b0, IMM_I, 32'h0, 8'h00, 1'b1, 1'b0);
        step();
        checkStatus("rs_end", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts a 32-bit RISC-V instruction word plus an immediate-format select over a valid/ready handshake, produces the sign- or zero-extended immediate at XLEN width one cycle later, and carries a caller tag alongside. A two-entry skid buffer sustains one transfer per cycle under downstream back-pressure. The block replaces the combinational immgen in pipelined cores and adds shift-amount and CSR-zimm formats.

## Interface

Parameters:
- XLEN, 32, output datapath width; legal values 32 or 64
- TAG_W, 8, width of the opaque side-band tag (PC index, rd, ROB id); minimum 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- in_instr  input  32  instruction word
- in_imm_src  input  3  immediate format select
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result this cycle
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of this result
- out_illegal  output  1  format/width violation for this result

## Operation

- Transfer: input on in_valid & in_ready; output on out_valid & out_ready, both at the rising edge.
- Formats (in_imm_src):
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25], instr[11:7]})
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 011 U: sext({instr[31:12], 12'b0}); upper 32 bits replicate bit 31 when XLEN=64
  - 100 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 101 SHAMT: zext(instr[25:20]) for XLEN=64; zext(instr[24:20]) for XLEN=32
  - 110 ZIMM: zext(instr[19:15])
  - 111 NONE: all zeros
- out_illegal = 1 only for SHAMT with XLEN=32 and instr[25]=1. out_imm is still the zext(instr[24:20]) value.
- Immediate decode is combinational at the input; only the result, tag and illegal flag are stored. in_instr is not stored.
- Storage: output register (OR) plus skid register (SK). A state machine tracks occupancy:
  - EMPTY to ONE on accept.
  - ONE to EMPTY on drain with no accept.
  - ONE stays ONE on simultaneous accept and drain.
  - ONE to FULL on accept with no drain; the new entry goes to SK.
  - FULL to ONE on drain; SK moves to OR.
- in_ready = (state != FULL). It is a registered signal with no combinational path from out_ready.
- Order is preserved: OR is always the oldest entry.
- flush: the next state is EMPTY and all entries are discarded. A request presented in the flush cycle is dropped even if in_ready=1. Flush wins over every simultaneous event.
- Payload registers need no reset; valid/state bits do.

## Timing

- Reset values: out_valid=0, in_ready=1 at the first edge with rst_n=0; out_imm, out_tag and out_illegal are 0 after reset.
- Reset mid-operation behaves exactly like flush. It takes precedence over flush and over any handshake.
- Latency: an input accepted at edge N gives out_valid=1 after edge N, with the result available in cycle N+1.
- Throughput: 1 result per cycle while out_ready=1.
- Back-pressure: with out_ready=0, two inputs are accepted, then in_ready drops. in_ready rises again the cycle after the first drain.
- Output stability: while out_valid & !out_ready, out_imm, out_tag and out_illegal hold their values.

## Structure

- Shared package imm_pkg:
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_NONE) with the encodings above; the ALU decoder imports the same enum.
  - Occupancy state enum (EMPTY, ONE, FULL).
- Sub-module: imm_decode, the pure combinational format extractor (XLEN parameter). imm_gen_pipe instantiates it once ahead of the skid logic.

## Test plan

- XLEN=32, out_ready=1, back-to-back:
  - I 7FF00093 gives 000007FF.
  - I 80000093 gives FFFFF800.
  - S FE112E23 gives FFFFFFFC.
  - Each result arrives one cycle after its accept, with the matching tag.
- XLEN=64, all values sign-extended:
  - U 12345037 gives 0000000012345000.
  - J FFF0016F gives FFFFFFFFFFF00FFE.
  - B FE512EE3 gives FFFFFFFFFFFFFFFC.
- Other formats:
  - ZIMM 000FD073 gives 1F.
  - SHAMT 03F09093 gives 3F with illegal=0 at XLEN=64, and 1F with illegal=1 at XLEN=32.
  - NONE gives 0.
- Back-pressure:
  - Hold out_ready=0 and stream tags 1..4: only tags 1 and 2 are accepted, and in_ready drops.
  - Release out_ready: tags 1, 2, 3, 4 emerge in order with no loss and no duplicates, and output stays stable while stalled.
- Flush in state FULL while in_valid=1:
  - Next cycle: out_valid=0, in_ready=1; the flushed request never appears at the output.
- Assert rst_n=0 for one cycle mid-stream, then reissue:
  - out_valid=0 and in_ready=1 after the reset edge.
  - The first post-reset result arrives with latency 1.
